l2_port_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared level-2 cache interface of the MIPS CPU. It accepts miss refills and write-throughs from the instruction cache (port 0) and the data cache (port 1) and serialises them onto the single level-2 port. It stalls each requester until its own transaction completes and returns the refilled 128-bit block to the requester that owns it. It sits between both L1 caches and the level-2 cache.

---
 rtl/l2_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// l2_port_arbiter
//
// Two-port arbiter and sequencer in front of the shared level-2 cache port.
// Port 0 is the instruction cache, port 1 the data cache. Each port raises
// read or write and holds it; the arbiter grants one port at a time, runs a
// single level-2 transaction for it, pulses that port's done and, for a read,
// hands the refilled 128-bit block back to that port only.
//
// Transaction sequence (one state per cycle, WAIT may repeat):
//   IDLE  -> grant a pending port, latch op/addr/wdata
//   ISSUE -> level-2 command is on the bus (registered outputs)
//   WAIT  -> command held until stall_level_2 drops
//   DONE  -> command dropped, done pulse, last_grant updated
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   p0_read, p0_write                port 0 request, held until p0_done
//   p0_addr, p0_wdata                port 0 address / write data
//   p0_stall                         port 0 must hold (combinational)
//   p0_done                          port 0 one-cycle completion pulse
//   p0_block                         last refill block returned to port 0
//   p1_*                             same set for port 1
//   mem_read_index, mem_write_index  level-2 read / write command
//   addr_to_mem, data_to_mem         level-2 address / write data
//   stall_level_2                    level-2 busy
//   block_of_data_from_cache_level_2 level-2 read data, valid when not stalled
//   timeout_err                      sticky abort flag
//
// Configuration:
//   L2_ARB_TIMEOUT_EN  when defined, a WAIT that stays stalled for
//                      TIMEOUT_CYCLES cycles is abandoned: done still pulses,
//                      the block is not updated and timeout_err is set until
//                      reset. When undefined, WAIT lasts as long as the stall
//                      and timeout_err is tied low.
// -----------------------------------------------------------------------------
module l2_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         p0_read,
  input  logic         p0_write,
  input  logic [31:0]  p0_addr,
  input  logic [31:0]  p0_wdata,
  output logic         p0_stall,
  output logic         p0_done,
  output logic [127:0] p0_block,

  input  logic         p1_read,
  input  logic         p1_write,
  input  logic [31:0]  p1_addr,
  input  logic [31:0]  p1_wdata,
  output logic         p1_stall,
  output logic         p1_done,
  output logic [127:0] p1_block,

  output logic         mem_read_index,
  output logic         mem_write_index,
  output logic [31:0]  addr_to_mem,
  output logic [31:0]  data_to_mem,
  input  logic         stall_level_2,
  input  logic [127:0] block_of_data_from_cache_level_2,

  output logic         timeout_err
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Granted transaction. The address and write data of the granted request
  // live directly in addr_to_mem / data_to_mem, which are registered outputs.
  logic       gnt_port_q;   // 0: port 0, 1: port 1
  logic       gnt_read_q;   // 1: read refill, 0: write-through
  logic       last_grant_q; // port served by the most recent transaction

  // ---------------------------------------------------------------------------
  // Request decode and arbitration
  // ---------------------------------------------------------------------------
  logic        p0_pend;
  logic        p1_pend;
  logic        any_pend;
  logic        grant_port;
  logic        sel_read;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  assign p0_pend  = p0_read | p0_write;
  assign p1_pend  = p1_read | p1_write;
  assign any_pend = p0_pend | p1_pend;

  // On a tie the port that was not served last wins; otherwise the single
  // pending port wins. With nothing pending the value is unused.
  assign grant_port = (p0_pend & p1_pend) ? ~last_grant_q : p1_pend;

  // Read takes priority over write on the same port; a simultaneous write is
  // dropped, so the op is "read" whenever read is high, else "write".
  assign sel_read  = grant_port ? p1_read  : p0_read;
  assign sel_addr  = grant_port ? p1_addr  : p0_addr;
  assign sel_wdata = grant_port ? p1_wdata : p0_wdata;

  // ---------------------------------------------------------------------------
  // WAIT exit conditions
  // ---------------------------------------------------------------------------
  logic in_wait;
  logic wait_complete;  // level-2 accepted / returned data
  logic timeout_hit;    // level-2 still busy after the allowed WAIT cycles
  logic wait_exit;

  assign in_wait       = (state_q == ST_WAIT);
  assign wait_complete = in_wait & ~stall_level_2;
  assign wait_exit     = wait_complete | timeout_hit;

`ifdef L2_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  // Counts stalled WAIT cycles. It is cleared in ISSUE so the first WAIT cycle
  // starts from zero; the abort fires on the stalled cycle that brings the
  // count to TIMEOUT_LIMIT, which is the last WAIT cycle.
  logic [7:0] wait_cnt_q;

  assign timeout_hit = in_wait & stall_level_2 &
                       (wait_cnt_q == (TIMEOUT_LIMIT - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= 8'd0;
    end else if (in_wait && stall_level_2) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_pend)  state_d = ST_ISSUE;
      ST_ISSUE:                state_d = ST_WAIT;
      ST_WAIT:  if (wait_exit) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_port_q   <= 1'b0;
      gnt_read_q   <= 1'b0;
      last_grant_q <= 1'b1;  // port 0 wins the first tie after reset
    end else begin
      if (state_q == ST_IDLE && any_pend) begin
        gnt_port_q <= grant_port;
        gnt_read_q <= sel_read;
      end
      if (state_q == ST_DONE) begin
        last_grant_q <= gnt_port_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Level-2 command outputs
  //
  // The command is set on the IDLE->ISSUE edge and cleared on the WAIT->DONE
  // edge, so the indices are high from ISSUE through the last WAIT cycle.
  // Address and write data stay put between transactions; the write data is
  // only replaced by a write grant.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_index  <= 1'b0;
      mem_write_index <= 1'b0;
      addr_to_mem     <= 32'd0;
      data_to_mem     <= 32'd0;
    end else begin
      if (state_q == ST_IDLE && any_pend) begin
        mem_read_index  <= sel_read;
        mem_write_index <= ~sel_read;
        addr_to_mem     <= sel_addr;
        if (!sel_read) begin
          data_to_mem <= sel_wdata;
        end
      end else if (wait_exit) begin
        mem_read_index  <= 1'b0;
        mem_write_index <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion pulses
  //
  // Raised on the WAIT->DONE edge so they are high exactly in the DONE cycle.
  // A requester that dropped its request meanwhile still gets the pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
    end else begin
      p0_done <= wait_exit & ~gnt_port_q;
      p1_done <= wait_exit &  gnt_port_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Refill blocks
  //
  // Each port's block only changes on a completed read for that port. An
  // aborted (timed-out) read leaves it untouched because wait_complete
  // requires the stall to be low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these wide data registers are reset on purpose: requesters may
      // look at the block before any refill and must see zero, not X.
      p0_block <= 128'd0;
      p1_block <= 128'd0;
    end else if (wait_complete && gnt_read_q) begin
      if (gnt_port_q) begin
        p1_block <= block_of_data_from_cache_level_2;
      end else begin
        p0_block <= block_of_data_from_cache_level_2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stalls
  //
  // Purely combinational: a requesting port is released only in the cycle its
  // done pulse is high, so the port not being served stays stalled throughout.
  // ---------------------------------------------------------------------------
  assign p0_stall = p0_pend & ~p0_done;
  assign p1_stall = p1_pend & ~p1_done;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_port_arbiter
//
// Drives l2_port_arbiter with directed scenarios followed by randomized
// traffic. A transaction-level reference model (grant time, completion time,
// returned blocks) predicts every output each cycle; a few literal checks pin
// the model's timing and arbitration against hand-computed values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_l2_port_arbiter;

  localparam int TO_CYCLES = 4;

  logic         clk;
  logic         rst_n;
  logic         p0_read, p0_write, p1_read, p1_write;
  logic [31:0]  p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic         p0_stall, p0_done, p1_stall, p1_done;
  logic [127:0] p0_block, p1_block;
  logic         mem_read_index, mem_write_index;
  logic [31:0]  addr_to_mem, data_to_mem;
  logic         stall_level_2;
  logic [127:0] l2_block;
  logic         timeout_err;

  l2_port_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk                              (clk),
    .rst_n                            (rst_n),
    .p0_read                          (p0_read),
    .p0_write                         (p0_write),
    .p0_addr                          (p0_addr),
    .p0_wdata                         (p0_wdata),
    .p0_stall                         (p0_stall),
    .p0_done                          (p0_done),
    .p0_block                         (p0_block),
    .p1_read                          (p1_read),
    .p1_write                         (p1_write),
    .p1_addr                          (p1_addr),
    .p1_wdata                         (p1_wdata),
    .p1_stall                         (p1_stall),
    .p1_done                          (p1_done),
    .p1_block                         (p1_block),
    .mem_read_index                   (mem_read_index),
    .mem_write_index                  (mem_write_index),
    .addr_to_mem                      (addr_to_mem),
    .data_to_mem                      (data_to_mem),
    .stall_level_2                    (stall_level_2),
    .block_of_data_from_cache_level_2 (l2_block),
    .timeout_err                      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transaction in flight, described by when it was
  // granted (t0) and when its done cycle is (done_at, -1 while unknown).
  // ---------------------------------------------------------------------------
  int           mc;
  bit           tx_act;
  int           tx_port;
  bit           tx_rd;
  int           tx_t0;
  int           tx_done_at;
  bit           m_last;
  logic [127:0] m_blk0, m_blk1;
  bit           m_terr;
  logic [31:0]  m_addr, m_data;

  // Values sampled in the most recent tick.
  logic s_done0, s_done1, s_rd, s_wr, s_stall1;

  task automatic model_reset();
    mc = 0; tx_act = 0; tx_port = 0; tx_rd = 0; tx_t0 = 0; tx_done_at = -1;
    m_last = 1'b1; m_blk0 = '0; m_blk1 = '0; m_terr = 0; m_addr = '0; m_data = '0;
    s_done0 = 0; s_done1 = 0; s_rd = 0; s_wr = 0; s_stall1 = 0;
  endtask

  task automatic model_cycle();
    bit busy, e_done0, e_done1, pend0, pend1;
    int port;
    busy    = tx_act && (mc >= tx_t0 + 1) && (tx_done_at < 0 || mc < tx_done_at);
    e_done0 = tx_act && (mc == tx_done_at) && (tx_port == 0);
    e_done1 = tx_act && (mc == tx_done_at) && (tx_port == 1);
    pend0   = p0_read | p0_write;
    pend1   = p1_read | p1_write;

    check("mem_read_index",  mem_read_index,  busy && tx_rd);
    check("mem_write_index", mem_write_index, busy && !tx_rd);
    check("addr_to_mem",     addr_to_mem,     m_addr);
    check("data_to_mem",     data_to_mem,     m_data);
    check("p0_done",         p0_done,         e_done0);
    check("p1_done",         p1_done,         e_done1);
    check("p0_stall",        p0_stall,        pend0 && !e_done0);
    check("p1_stall",        p1_stall,        pend1 && !e_done1);
    check("p0_block",        p0_block,        m_blk0);
    check("p1_block",        p1_block,        m_blk1);
    check("timeout_err",     timeout_err,     m_terr);

    if (!tx_act) begin
      if (pend0 || pend1) begin
        port       = (pend0 && pend1) ? int'(!m_last) : (pend1 ? 1 : 0);
        tx_act     = 1;
        tx_port    = port;
        tx_rd      = (port == 1) ? p1_read : p0_read;
        tx_t0      = mc;
        tx_done_at = -1;
        m_addr     = (port == 1) ? p1_addr : p0_addr;
        if (!tx_rd) m_data = (port == 1) ? p1_wdata : p0_wdata;
      end
    end else if (mc == tx_done_at) begin
      m_last = (tx_port == 1);
      tx_act = 0;
    end else if (tx_done_at < 0 && mc >= tx_t0 + 2) begin
      if (!stall_level_2) begin
        tx_done_at = mc + 1;
        if (tx_rd) begin
          if (tx_port == 1) m_blk1 = l2_block; else m_blk0 = l2_block;
        end
      end
`ifdef L2_ARB_TIMEOUT_EN
      else if (mc - (tx_t0 + 2) + 1 == TO_CYCLES) begin
        tx_done_at = mc + 1;
        m_terr     = 1;
      end
`endif
    end
    mc++;
  endtask

  // One cycle: sample mid-cycle, check against the model, then move to the
  // start of the next cycle where the caller drives new inputs.
  task automatic tick();
    @(negedge clk);
    s_done0  = p0_done;
    s_done1  = p1_done;
    s_rd     = mem_read_index;
    s_wr     = mem_write_index;
    s_stall1 = p1_stall;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
    p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
    stall_level_2 = 0; l2_block = '0;
    #1;
    check("rst_mem_read_index",  mem_read_index,  0);
    check("rst_mem_write_index", mem_write_index, 0);
    check("rst_addr_to_mem",     addr_to_mem,     0);
    check("rst_data_to_mem",     data_to_mem,     0);
    check("rst_done",            {p0_done, p1_done},   0);
    check("rst_stall",           {p0_stall, p1_stall}, 0);
    check("rst_p0_block",        p0_block,        0);
    check("rst_p1_block",        p1_block,        0);
    check("rst_timeout_err",     timeout_err,     0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_no_done", {p0_done, p1_done}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // Directed run: stall_hi < 0 keeps the stall high, otherwise the stall is
  // high for the first stall_hi cycles. Records done offsets, command lengths,
  // port 1 stall length and grant order.
  int d0, d1, rdc, wrc, st1, n_ord;
  int ord [4];

  task automatic run(input int n, input bit auto_drop, input int stall_hi);
    d0 = -1; d1 = -1; rdc = 0; wrc = 0; st1 = 0; n_ord = 0;
    for (int k = 0; k < 4; k++) ord[k] = -1;
    for (int i = 0; i < n; i++) begin
      stall_level_2 = (stall_hi < 0) ? 1'b1 : (i < stall_hi);
      tick();
      if (s_done0 && d0 < 0) d0 = i;
      if (s_done1 && d1 < 0) d1 = i;
      if (s_rd) rdc++;
      if (s_wr) wrc++;
      if (s_stall1) st1++;
      if (s_done0) begin
        if (n_ord < 4) begin ord[n_ord] = 0; n_ord++; end
        if (auto_drop) begin p0_read = 0; p0_write = 0; end
      end
      if (s_done1) begin
        if (n_ord < 4) begin ord[n_ord] = 1; n_ord++; end
        if (auto_drop) begin p1_read = 0; p1_write = 0; end
      end
    end
  endtask

  task automatic new_req(input int p);
    int op;
    op = $urandom_range(0, 2);  // 0 read, 1 write, 2 read+write
    if (p == 0) begin
      p0_read = (op != 1); p0_write = (op != 0);
      p0_addr = $urandom;  p0_wdata = $urandom;
    end else begin
      p1_read = (op != 1); p1_write = (op != 0);
      p1_addr = $urandom;  p1_wdata = $urandom;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) begin p0_read = 0; p0_write = 0; end
    else        begin p1_read = 0; p1_write = 0; end
  endtask

  localparam logic [127:0] BLK_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] BLK_B = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

  initial begin
    bit act, dn;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Single read on port 0.
    p0_read = 1; p0_addr = 32'h40; l2_block = BLK_A;
    run(6, 1, 0);
    check("single_done_offset", d0, 3);
    check("single_read_len",    rdc, 2);
    check("single_no_p1_done",  d1, -1);
    check("single_p0_block",    p0_block, BLK_A);
    check("single_p1_block",    p1_block, 0);

    // First tie after reset: port 0 first, port 1 stalled until its done.
    do_reset();
    p0_read = 1; p0_addr = 32'h100; p1_read = 1; p1_addr = 32'h200; l2_block = BLK_B;
    run(10, 1, 0);
    check("tie_p0_done_offset", d0, 3);
    check("tie_p1_done_offset", d1, 7);
    check("tie_p1_stall_len",   st1, 7);
    check("tie_first_grant",    ord[0], 0);
    check("tie_second_grant",   ord[1], 1);

    // Sustained double load alternates.
    p0_read = 1; p1_read = 1;
    run(16, 0, 0);
    check("alt_grant_0", ord[0], 0);
    check("alt_grant_1", ord[1], 1);
    check("alt_grant_2", ord[2], 0);
    check("alt_grant_3", ord[3], 1);
    p0_read = 0; p1_read = 0;

    // Write on port 1 with five stalled WAIT cycles.
    p1_write = 1; p1_wdata = 32'hDEADBEEF; p1_addr = 32'h300;
    l2_block = {4{32'hFFFF0000}};
    run(12, 1, 7);
    check("write_done_offset", d1, 8);
    check("write_cmd_len",     wrc, 7);
    check("write_data_to_mem", data_to_mem, 32'hDEADBEEF);
    check("write_p1_block",    p1_block, BLK_B);

    // Reset while in WAIT, then a fresh grant.
    p0_read = 1; p0_addr = 32'h500;
    run(3, 0, -1);
    check("pre_reset_in_wait", mem_read_index, 1);
    do_reset();
    p1_read = 1; p1_addr = 32'h600; l2_block = BLK_A;
    run(6, 1, 0);
    check("post_reset_p1_done", d1, 3);
    check("post_reset_no_p0",   d0, -1);
    check("post_reset_p1_blk",  p1_block, BLK_A);

    // Permanent level-2 stall.
    do_reset();
    p0_read = 1; p0_addr = 32'h700; l2_block = BLK_B;
    run(10, 1, -1);
`ifdef L2_ARB_TIMEOUT_EN
    check("timeout_done_offset", d0, 6);
    check("timeout_err_set",     timeout_err, 1);
    check("timeout_block_kept",  p0_block, 0);
    run(4, 1, -1);
    check("timeout_err_sticky",  timeout_err, 1);
`else
    check("no_timeout_done",     d0, -1);
    check("no_timeout_err",      timeout_err, 0);
    check("no_timeout_in_wait",  mem_read_index, 1);
`endif
    do_reset();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 2; p++) begin
        act = (p == 0) ? (p0_read | p0_write) : (p1_read | p1_write);
        dn  = (p == 0) ? s_done0 : s_done1;
        if (dn) begin
          if ($urandom_range(0, 1) == 1) new_req(p); else drop_req(p);
        end else if (!act) begin
          if ($urandom_range(0, 3) == 0) new_req(p);
        end else if ($urandom_range(0, 63) == 0) begin
          drop_req(p);
        end
      end
      stall_level_2 = ($urandom_range(0, 99) < 55);
      l2_block = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
